// File: rtl/prio_select_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : prio_select_pipe_if
// Description : Request/response bundle for prio_select_pipe. The master side
//               sources sel/data and consumes the selected word.
// Revision    : 1.0 - initial release
// ============================================================================
interface prio_select_pipe_if #(
    parameter int NCH = 6,
    parameter int DW  = 4
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                in_valid;
    logic                in_ready;
    logic [SW-1:0]       sel;
    logic [NCH*DW-1:0]   data;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic [SW-1:0]       out_slot;
    logic [SW-1:0]       out_src;
    logic                out_none;
    logic [15:0]         acc_cnt;

    modport master (
        output in_valid, sel, data, out_ready,
        input  in_ready, out_valid, out_data, out_slot, out_src, out_none, acc_cnt
    );

    modport slave (
        input  in_valid, sel, data, out_ready,
        output in_ready, out_valid, out_data, out_slot, out_src, out_none, acc_cnt
    );
endinterface
`default_nettype wire

// File: rtl/prio_select_pipe.sv
`default_nettype none
// ============================================================================
// Module      : prio_select_pipe
// Description : Rotates NCH channels by sel, picks one non-zero slot (fixed
//               priority or round-robin) and registers the winner behind a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_select_pipe #(
    parameter int NCH     = 6,
    parameter int DW      = 4,
    parameter int RR_MODE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    prio_select_pipe_if.slave  bus
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              w_sel_ok;
    logic [DW-1:0]     w_slot_val [NCH];
    logic [SW-1:0]     w_slot_src [NCH];
    logic              w_found;
    logic [SW-1:0]     w_win;
    int                w_idx;
    logic              w_in_ready;
    logic              w_accept;

    logic              r_out_valid;
    logic [DW-1:0]     r_out_data;
    logic [SW-1:0]     r_out_slot;
    logic [SW-1:0]     r_out_src;
    logic              r_out_none;
    logic [15:0]       r_acc_cnt;
    logic [SW-1:0]     r_ptr;

    // An out-of-range select blanks every slot, so it naturally yields "none".
    assign w_sel_ok   = (int'(bus.sel) < NCH);
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Rotation map: slot0 takes channel sel, lower slots shift up by one.
    always_comb begin
        for (int s = 0; s < NCH; s++) begin
            if (s == 0) begin
                w_slot_src[s] = bus.sel;
            end else if (s <= int'(bus.sel)) begin
                w_slot_src[s] = SW'(s - 1);
            end else begin
                w_slot_src[s] = SW'(s);
            end
            w_slot_val[s] = '0;
            for (int c = 0; c < NCH; c++) begin
                if (w_sel_ok && (int'(w_slot_src[s]) == c)) begin
                    w_slot_val[s] = bus.data[c*DW +: DW];
                end
            end
        end
    end

    // Winner search: highest non-zero slot, or first non-zero from r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        if (RR_MODE == 0) begin
            for (int s = 0; s < NCH; s++) begin
                if (w_slot_val[s] != '0) begin
                    w_found = 1'b1;
                    w_win   = SW'(s);
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                w_idx = int'(r_ptr) + i;
                if (w_idx >= NCH) begin
                    w_idx = w_idx - NCH;
                end
                if (!w_found && (w_slot_val[w_idx] != '0)) begin
                    w_found = 1'b1;
                    w_win   = SW'(w_idx);
                end
            end
        end
    end

    // Output register: load on accept (even while retiring), clear valid on retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_slot  <= '0;
            r_out_src   <= '0;
            r_out_none  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_found ? w_slot_val[w_win] : '0;
            r_out_slot  <= w_found ? w_win : '0;
            r_out_src   <= w_found ? w_slot_src[w_win] : '0;
            r_out_none  <= !w_found;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Accepted-request counter, saturating rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
        end else if (w_accept && (r_acc_cnt != 16'hFFFF)) begin
            r_acc_cnt <= r_acc_cnt + 16'd1;
        end
    end

    // Round-robin pointer moves past the winner; frozen on "none" and in fixed mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if ((RR_MODE != 0) && w_accept && w_found) begin
            r_ptr <= (w_win == SW'(NCH - 1)) ? '0 : w_win + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_slot  = r_out_slot;
    assign bus.out_src   = r_out_src;
    assign bus.out_none  = r_out_none;
    assign bus.acc_cnt   = r_acc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prio_select_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_prio_select_pipe
// Description : Self-checking bench driving a fixed-priority and a
//               round-robin instance with identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_select_pipe;
    localparam int NCH = 6;
    localparam int DW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [2:0]    sel = '0;
    logic [23:0]   data = '0;

    int total = 0;
    int bad   = 0;

    // Reference state, index 0 = fixed instance, 1 = round-robin instance
    logic          m_valid [2];
    logic [3:0]    m_data  [2];
    int            m_slot  [2];
    int            m_src   [2];
    logic          m_none  [2];
    int            m_cnt   [2];
    int            m_ptr   [2];

    always #5 clk = ~clk;

    prio_select_pipe_if #(.NCH(NCH), .DW(DW)) bus_fp ();
    prio_select_pipe_if #(.NCH(NCH), .DW(DW)) bus_rr ();

    assign bus_fp.in_valid  = in_valid;
    assign bus_fp.sel       = sel;
    assign bus_fp.data      = data;
    assign bus_fp.out_ready = out_ready;
    assign bus_rr.in_valid  = in_valid;
    assign bus_rr.sel       = sel;
    assign bus_rr.data      = data;
    assign bus_rr.out_ready = out_ready;

    prio_select_pipe #(.NCH(NCH), .DW(DW), .RR_MODE(0)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fp.slave)
    );

    prio_select_pipe #(.NCH(NCH), .DW(DW), .RR_MODE(1)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_rr.slave)
    );

    function automatic logic [28:0] dut_word(input int k);
        if (k == 0)
            return {bus_fp.in_ready, bus_fp.out_valid, bus_fp.out_data, bus_fp.out_slot,
                    bus_fp.out_src, bus_fp.out_none, bus_fp.acc_cnt};
        return {bus_rr.in_ready, bus_rr.out_valid, bus_rr.out_data, bus_rr.out_slot,
                bus_rr.out_src, bus_rr.out_none, bus_rr.acc_cnt};
    endfunction

    function automatic logic [28:0] exp_word(input int k);
        return {(!m_valid[k] || out_ready), m_valid[k], m_data[k], 3'(m_slot[k]),
                3'(m_src[k]), m_none[k], 16'(m_cnt[k])};
    endfunction

    // Place each channel into its rotated slot, then choose per mode.
    task automatic model_pick(input int mode, input int ptr, input int s, input logic [23:0] d,
                              output int wd, output int wslot, output int wsrc, output bit wnone);
        int sv [NCH];
        int sc [NCH];
        for (int i = 0; i < NCH; i++) begin
            sv[i] = 0;
            sc[i] = 0;
        end
        if (s < NCH) begin
            for (int c = 0; c < NCH; c++) begin
                int dst;
                dst = (c == s) ? 0 : ((c < s) ? c + 1 : c);
                sv[dst] = int'(d[c*DW +: DW]);
                sc[dst] = c;
            end
        end
        wnone = 1'b1;
        wd = 0;
        wslot = 0;
        wsrc = 0;
        if (mode == 0) begin
            for (int i = NCH - 1; i >= 0; i--)
                if (wnone && sv[i] != 0) begin
                    wnone = 1'b0;
                    wslot = i;
                end
        end else begin
            for (int i = 0; i < NCH; i++)
                if (wnone && sv[(ptr + i) % NCH] != 0) begin
                    wnone = 1'b0;
                    wslot = (ptr + i) % NCH;
                end
        end
        if (!wnone) begin
            wd = sv[wslot];
            wsrc = sc[wslot];
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            m_slot[k]  = 0;
            m_src[k]   = 0;
            m_none[k]  = 1'b0;
            m_cnt[k]   = 0;
            m_ptr[k]   = 0;
        end
    endtask

    task automatic model_clock();
        int wd, ws, wc;
        bit wn;
        for (int k = 0; k < 2; k++) begin
            if (in_valid && (!m_valid[k] || out_ready)) begin
                model_pick(k, m_ptr[k], int'(sel), data, wd, ws, wc, wn);
                m_valid[k] = 1'b1;
                m_data[k]  = 4'(wd);
                m_slot[k]  = ws;
                m_src[k]   = wc;
                m_none[k]  = wn;
                if (m_cnt[k] < 65535) m_cnt[k]++;
                if (k == 1 && !wn) m_ptr[k] = (ws + 1) % NCH;
            end else if (out_ready) begin
                m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [23:0] rand_data();
        logic [23:0] d;
        d = 24'($urandom);
        for (int c = 0; c < NCH; c++)
            if ($urandom_range(0, 2) == 0) d[c*DW +: DW] = '0;
        return d;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_word(k) !== exp_word(k)) begin
                bad++;
                $display("FAIL reset dut%0d got=%h exp=%h", k, dut_word(k), exp_word(k));
            end
        end
        total++;
        if ({bus_fp.out_valid, bus_fp.out_none, bus_fp.acc_cnt} !== 18'd0) begin
            bad++;
            $display("FAIL reset_zero got=%h exp=0", {bus_fp.out_valid, bus_fp.out_none, bus_fp.acc_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        logic [2:0]  sels  [4] = '{3'd0, 3'd5, 3'd6, 3'd7};
        logic [23:0] datas [4] = '{24'h654321, 24'h907000, 24'hFFFFFF, 24'hFFFFFF};
        logic [10:0] exps  [4] = '{{4'd6, 3'd5, 3'd5, 1'b0}, {4'd7, 3'd4, 3'd3, 1'b0},
                                   {4'd0, 3'd0, 3'd0, 1'b1}, {4'd0, 3'd0, 3'd0, 1'b1}};
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = sels[i];
            data = datas[i];
            step();
            total++;
            if ({bus_fp.out_data, bus_fp.out_slot, bus_fp.out_src, bus_fp.out_none} !== exps[i]) begin
                bad++;
                $display("FAIL fixed_dir%0d got=%h exp=%h", i,
                         {bus_fp.out_data, bus_fp.out_slot, bus_fp.out_src, bus_fp.out_none}, exps[i]);
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_word(k) !== exp_word(k)) begin
                    bad++;
                    $display("FAIL fixed%0d dut%0d got=%h exp=%h", i, k, dut_word(k), exp_word(k));
                end
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        out_ready = 1'b0;
        sel = 3'($urandom_range(0, 5));
        data = rand_data();
        step();
        for (int i = 0; i < 3; i++) begin
            sel = 3'($urandom_range(0, 7));
            data = rand_data();
            step();
            total++;
            if (bus_fp.in_ready !== 1'b0 || bus_fp.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall%0d in_ready/out_valid got=%b%b exp=01", i,
                         bus_fp.in_ready, bus_fp.out_valid);
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_word(k) !== exp_word(k)) begin
                    bad++;
                    $display("FAIL stall%0d dut%0d got=%h exp=%h", i, k, dut_word(k), exp_word(k));
                end
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'($urandom_range(0, 5));
            data = rand_data();
            step();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_word(k) !== exp_word(k)) begin
                    bad++;
                    $display("FAIL b2b%0d dut%0d got=%h exp=%h", i, k, dut_word(k), exp_word(k));
                end
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        apply_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        sel = 3'd0;
        data = 24'h111111;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (bus_rr.out_slot !== 3'(i) || bus_rr.out_none !== 1'b0) begin
                bad++;
                $display("FAIL rr_seq%0d slot got=%0d exp=%0d", i, bus_rr.out_slot, i);
            end
        end
        data = 24'h000010;
        step();
        total++;
        if (bus_rr.out_slot !== 3'd1 || dut_rr.r_ptr !== 3'd2) begin
            bad++;
            $display("FAIL rr_single slot/ptr got=%0d/%0d exp=1/2", bus_rr.out_slot, dut_rr.r_ptr);
        end
        data = 24'h000000;
        step();
        total++;
        if (bus_rr.out_none !== 1'b1 || dut_rr.r_ptr !== 3'd2) begin
            bad++;
            $display("FAIL rr_none none/ptr got=%b/%0d exp=1/2", bus_rr.out_none, dut_rr.r_ptr);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_word(k) !== exp_word(k)) begin
                bad++;
                $display("FAIL rr_end dut%0d got=%h exp=%h", k, dut_word(k), exp_word(k));
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            sel = 3'($urandom_range(0, 7));
            data = rand_data();
            step();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_word(k) !== exp_word(k)) begin
                    bad++;
                    $display("FAIL rand%0d dut%0d got=%h exp=%h", i, k, dut_word(k), exp_word(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        out_ready = 1'b0;
        sel = 3'd0;
        data = 24'h654321;
        step();
        total++;
        if (bus_fp.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre out_valid got=%b exp=1", bus_fp.out_valid);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_word(k) !== exp_word(k)) begin
                bad++;
                $display("FAIL midrst dut%0d got=%h exp=%h", k, dut_word(k), exp_word(k));
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut_fp.r_acc_cnt = 16'hFFFE;
        force dut_rr.r_acc_cnt = 16'hFFFE;
        #1;
        release dut_fp.r_acc_cnt;
        release dut_rr.r_acc_cnt;
        m_cnt[0] = 65534;
        m_cnt[1] = 65534;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sel = 3'($urandom_range(0, 5));
            data = rand_data();
            step();
            total++;
            if (bus_fp.acc_cnt !== 16'hFFFF || bus_rr.acc_cnt !== 16'hFFFF) begin
                bad++;
                $display("FAIL sat%0d acc_cnt got=%h/%h exp=ffff", i, bus_fp.acc_cnt, bus_rr.acc_cnt);
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_word(k) !== exp_word(k)) begin
                    bad++;
                    $display("FAIL sat%0d dut%0d got=%h exp=%h", i, k, dut_word(k), exp_word(k));
                end
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fixed();
        test_backpressure();
        test_round_robin();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/prio_select_pipe.md
Name: prio_select_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational rotate/priority-select mux.
- Rotates NCH data channels by a per-transaction select, then picks one non-zero slot, by fixed priority or round-robin.
- The chosen word, its slot and its source channel are registered behind a valid/ready handshake.
- Sits between the channel data sources and the downstream consumer of the selected word.

Parameters:
NCH, 6, number of input channels (>=2)
DW, 4, data width per channel
RR_MODE, 0, 0 = fixed priority (highest non-zero slot wins); 1 = round-robin over slots
SW, $clog2(NCH) (min 1), width of sel/slot/source fields (derived, do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request carries valid sel/data
in_ready  output  1  block can accept request this cycle
sel  input  SW  rotation select; values >= NCH are invalid
data  input  NCH*DW  channel k at bits [k*DW +: DW]
out_valid  output  1  output word valid
out_ready  input  1  consumer accepts output
out_data  output  DW  selected word
out_slot  output  SW  winning rotated slot index
out_src  output  SW  original channel index of winner
out_none  output  1  no non-zero slot (or invalid sel); out_data = 0
acc_cnt  output  16  accepted-request count, saturating at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_slot=0, out_src=0, out_none=0, acc_cnt=0, rr pointer=0. Reset mid-transaction drops the held word and returns the block to idle.
- Handshake: in_ready = !out_valid || out_ready. Request accepted when in_valid && in_ready. Output word retires when out_valid && out_ready.
- Accept and retire in the same cycle: the new word replaces the old one and out_valid stays 1, giving full throughput.
- out_* fields hold stable while out_valid && !out_ready.
- Latency: exactly 1 cycle from accept to out_valid.
- Rotation, valid sel=k: slot0 = ch k; slot s (1..k) = ch s-1; slot s (>k) = ch s.
- Rotation, sel >= NCH: all slots read as 0.
- Fixed mode: winner is the highest slot s with slot value != 0.
- Round-robin mode: scan slots ptr, ptr+1, ... with wrap mod NCH; winner is the first non-zero slot.
  - On accept with a winner g, ptr <= (g+1) mod NCH.
  - ptr is unchanged on out_none.
  - ptr is unchanged when fixed mode is selected.
- out_src is the source channel of the winning slot, per the rotation map.
- No winner (all slots zero or invalid sel): out_none=1, out_data=0, out_slot=0, out_src=0. The word is still issued with out_valid=1.
- acc_cnt increments on every accept and saturates at 16'hFFFF (no wrap).
- Combinational paths: only in_ready depends combinationally on out_ready. There is no combinational path from data/sel to any out_* port.

Test Plan:
- NCH=6, DW=4, fixed mode; sel=0, data ch0..5 = {1,2,3,4,5,6} -> next cycle out_data=6, out_slot=5, out_src=5, out_none=0.
- Fixed mode; sel=5, ch5=9, ch4=0, ch3=7, others 0 -> slot4=ch3 wins: out_data=7, out_slot=4, out_src=3.
- sel=6 (and sel=7), data all 4'hF -> out_data=0, out_none=1, out_slot=0, out_src=0.
- Backpressure: hold out_ready=0 for 3 cycles after one accept -> in_ready=0, out_* stable. Then out_ready=1 with in_valid=1 -> back-to-back transfers, one word per cycle, no loss or duplication.
- RR_MODE=1, sel=0, all channels = 1, four accepts -> out_slot sequence 0,1,2,3.
  - Then a request with only ch1 non-zero -> out_slot=1, next ptr=2.
  - Then an all-zero request -> out_none=1, ptr stays 2.
- Assert rst_n low mid-stream with out_valid=1 -> out_valid=0 and acc_cnt=0 immediately.
  - Force acc_cnt to 16'hFFFE, then two accepts -> acc_cnt stays at 16'hFFFF.
